multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the RISC-V datapath. It replaces the single-step registered decoder with a state machine that sequences fetch, decode, execute, memory and writeback. It supports configurable memory latency and adds branch resolution, illegal-instruction trapping and a retired-instruction counter. It sits between instruction memory/IR and the datapath muxes, ALU, register file and data memory.

---
 rtl/multicycle_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback for a RISC-V datapath
module multicycle_control #(
   parameter int ALUCTL_W = 4,
   parameter int MEM_LAT  = 0,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7b5,
   input  logic                zero,
   output logic                pcwrite,
   output logic                irwrite,
   output logic                pcsrc,
   output logic                alusrc_a,
   output logic [1:0]          alusrc_b,
   output logic [ALUCTL_W-1:0] alucontrol,
   output logic                memread,
   output logic                memwrite,
   output logic                regwrite,
   output logic                memtoreg,
   output logic                branch_taken,
   output logic                retire,
   output logic                illegal,
   output logic                busy,
   output logic [CNT_W-1:0]    instret
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] op_q, op_d;
   logic [2:0] f3_q, f3_d;
   logic b5_q, b5_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic is_lw, is_sw, is_r, is_i, is_br, ri_ok, legal, last;
   logic [3:0] alu_op;
   always_comb begin
      is_lw = op_q == 7'b0000011;
      is_sw = op_q == 7'b0100011;
      is_r  = op_q == 7'b0110011;
      is_i  = op_q == 7'b0010011;
      is_br = op_q == 7'b1100011;
      // slt/sltu are unsupported, and b5 only distinguishes add/sub and srl/sra
      ri_ok = f3_q != 3'b010 && f3_q != 3'b011 && !(f3_q == 3'b101 && b5_q);
      legal = is_lw || is_sw || ((is_r || is_i) && ri_ok) || (is_br && f3_q[2:1] == 2'b00);
      last  = cnt_q == 4'(MEM_LAT);
      case (f3_q)
         3'b000:  alu_op = (is_r && b5_q) ? 4'b0110 : 4'b0010;
         3'b100:  alu_op = 4'b0011;
         3'b110:  alu_op = 4'b0001;
         3'b111:  alu_op = 4'b0000;
         3'b001:  alu_op = 4'b0100;
         3'b101:  alu_op = 4'b0101;
         default: alu_op = 4'b0010;
      endcase
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      op_d = op_q;
      f3_d = f3_q;
      b5_d = b5_q;
      instret_d = instret_q;
      pcwrite = 1'b0;
      irwrite = 1'b0;
      pcsrc = 1'b0;
      alusrc_a = 1'b0;
      alusrc_b = 2'd0;
      alucontrol = '0;
      memread = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      memtoreg = 1'b0;
      branch_taken = 1'b0;
      retire = 1'b0;
      case (state_q)
         IDLE: state_d = en ? FETCH : IDLE;
         FETCH: begin
            memread = 1'b1;
            alusrc_b = 2'd2;
            alucontrol = ALUCTL_W'(4'b0010);
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
            if (last) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               op_d = opcode;
               f3_d = funct3;
               b5_d = funct7b5;
               state_d = DECODE;
            end
         end
         DECODE: state_d = legal ? EXEC : TRAP;
         EXEC: begin
            alusrc_a = 1'b1;
            alusrc_b = is_r || is_br ? 2'd0 : 2'd1;
            alucontrol = ALUCTL_W'(is_br ? 4'b0110 : (is_lw || is_sw) ? 4'b0010 : alu_op);
            pcsrc = is_br;
            branch_taken = is_br && (zero ^ f3_q[0]);
            pcwrite = branch_taken;
            retire = is_br;
            state_d = (is_lw || is_sw) ? MEM : WB;
         end
         MEM: begin
            memread = is_lw;
            memwrite = is_sw && last;
            retire = is_sw && last;
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
            if (last && is_lw) state_d = WB;
         end
         WB: begin
            regwrite = 1'b1;
            memtoreg = is_lw;
            retire = 1'b1;
         end
         default: ;
      endcase
      if (retire) begin
         instret_d = instret_q + CNT_W'(1);
         state_d = en ? FETCH : IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         op_q <= '0;
         f3_q <= '0;
         b5_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         op_q <= op_d;
         f3_q <= f3_d;
         b5_q <= b5_d;
         instret_q <= instret_d;
      end
   end
   assign illegal = state_q == TRAP;
   assign busy = state_q != IDLE && state_q != TRAP;
   assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed cycle-by-cycle checks of the multicycle control FSM (MEM_LAT=2, CNT_W=4)
module tb_multicycle_control;
   logic clk, reset, en, funct7b5, zero;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic pcwrite, irwrite, pcsrc, alusrc_a, memread, memwrite, regwrite, memtoreg;
   logic branch_taken, retire, illegal, busy;
   logic [1:0] alusrc_b;
   logic [3:0] alucontrol, instret;
   logic [17:0] ctl, fx, fl, dc, idl;
   int checks = 0, failures = 0;

   multicycle_control #(.ALUCTL_W(4), .MEM_LAT(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite), .irwrite(irwrite),
      .pcsrc(pcsrc), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alucontrol(alucontrol),
      .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
      .branch_taken(branch_taken), .retire(retire), .illegal(illegal), .busy(busy),
      .instret(instret)
   );

   assign ctl = {pcwrite, irwrite, pcsrc, alusrc_a, alusrc_b, alucontrol, memread, memwrite,
                 regwrite, memtoreg, branch_taken, retire, illegal, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [17:0] cv(input logic pw, iw, ps, sa, input logic [1:0] sb,
                                      input logic [3:0] al, input logic mr, mw, rw, mt, bt, rt, il, by);
      return {pw, iw, ps, sa, sb, al, mr, mw, rw, mt, bt, rt, il, by};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic b5);
      opcode = op;
      funct3 = f3;
      funct7b5 = b5;
   endtask

   task automatic fetch_dec(input string t);
      tick(); chk({t, ".f0"}, ctl, fx);
      tick(); chk({t, ".f1"}, ctl, fx);
      tick(); chk({t, ".f2"}, ctl, fl);
      tick(); chk({t, ".dec"}, ctl, dc);
   endtask

   initial begin
      fx  = cv(0,0,0,0,2'd2,4'h2,1,0,0,0,0,0,0,1);
      fl  = cv(1,1,0,0,2'd2,4'h2,1,0,0,0,0,0,0,1);
      dc  = cv(0,0,0,0,2'd0,4'h0,0,0,0,0,0,0,0,1);
      idl = '0;
      reset = 1'b1; en = 1'b0; zero = 1'b0;
      set_ins(7'b0, 3'b0, 1'b0);
      tick(); tick();
      reset = 1'b0;
      chk("reset.ctl", ctl, idl);
      chk("reset.instret", instret, 0);
      tick(); chk("idle.hold", ctl, idl);

      // R add
      set_ins(7'b0110011, 3'b000, 1'b0); en = 1'b1;
      fetch_dec("add");
      tick(); chk("add.exec", ctl, cv(0,0,0,1,2'd0,4'h2,0,0,0,0,0,0,0,1));
      en = 1'b0;
      tick(); chk("add.wb", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,1,0,0,1,0,1));
      chk("add.cnt_before", instret, 0);
      tick(); chk("add.idle", ctl, idl);
      chk("add.instret", instret, 1);

      // R sub
      set_ins(7'b0110011, 3'b000, 1'b1); en = 1'b1;
      fetch_dec("sub");
      tick(); chk("sub.exec", ctl, cv(0,0,0,1,2'd0,4'h6,0,0,0,0,0,0,0,1));
      en = 1'b0;
      tick(); chk("sub.wb", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,1,0,0,1,0,1));
      tick(); chk("sub.instret", instret, 2);

      // xori retiring with en=1 goes straight to FETCH
      set_ins(7'b0010011, 3'b100, 1'b1); en = 1'b1;
      fetch_dec("xori");
      tick(); chk("xori.exec", ctl, cv(0,0,0,1,2'd1,4'h3,0,0,0,0,0,0,0,1));
      tick(); chk("xori.wb", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,1,0,0,1,0,1));
      tick(); chk("xori.refetch", ctl, fx);
      set_ins(7'b0010011, 3'b000, 1'b0);
      tick(); chk("addi.f1", ctl, fx);
      tick(); chk("addi.f2", ctl, fl);
      tick(); chk("addi.dec", ctl, dc);
      tick(); chk("addi.exec", ctl, cv(0,0,0,1,2'd1,4'h2,0,0,0,0,0,0,0,1));
      en = 1'b0;
      tick(); chk("addi.wb", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,1,0,0,1,0,1));
      tick(); chk("addi.idle", ctl, idl);
      chk("addi.instret", instret, 4);
      tick(); chk("addi.idle2", ctl, idl);
      en = 1'b1;
      tick(); chk("en.refetch", ctl, fx);

      // lw, already in first fetch cycle
      set_ins(7'b0000011, 3'b010, 1'b0);
      tick(); chk("lw.f1", ctl, fx);
      tick(); chk("lw.f2", ctl, fl);
      tick(); chk("lw.dec", ctl, dc);
      tick(); chk("lw.exec", ctl, cv(0,0,0,1,2'd1,4'h2,0,0,0,0,0,0,0,1));
      tick(); chk("lw.m0", ctl, cv(0,0,0,0,2'd0,4'h0,1,0,0,0,0,0,0,1));
      tick(); chk("lw.m1", ctl, cv(0,0,0,0,2'd0,4'h0,1,0,0,0,0,0,0,1));
      en = 1'b0;
      tick(); chk("lw.m2", ctl, cv(0,0,0,0,2'd0,4'h0,1,0,0,0,0,0,0,1));
      tick(); chk("lw.wb", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,1,1,0,1,0,1));
      tick(); chk("lw.idle", ctl, idl);
      chk("lw.instret", instret, 5);

      // sw
      set_ins(7'b0100011, 3'b010, 1'b0); en = 1'b1;
      fetch_dec("sw");
      tick(); chk("sw.exec", ctl, cv(0,0,0,1,2'd1,4'h2,0,0,0,0,0,0,0,1));
      tick(); chk("sw.m0", ctl, dc);
      tick(); chk("sw.m1", ctl, dc);
      en = 1'b0;
      tick(); chk("sw.m2", ctl, cv(0,0,0,0,2'd0,4'h0,0,1,0,0,0,1,0,1));
      tick(); chk("sw.idle", ctl, idl);
      chk("sw.instret", instret, 6);

      // branches
      set_ins(7'b1100011, 3'b000, 1'b0); zero = 1'b1; en = 1'b1;
      fetch_dec("beq1");
      en = 1'b0;
      tick(); chk("beq1.exec", ctl, cv(1,0,1,1,2'd0,4'h6,0,0,0,0,1,1,0,1));
      tick(); chk("beq1.idle", ctl, idl);
      zero = 1'b0; en = 1'b1;
      fetch_dec("beq0");
      en = 1'b0;
      tick(); chk("beq0.exec", ctl, cv(0,0,1,1,2'd0,4'h6,0,0,0,0,0,1,0,1));
      tick(); chk("beq0.idle", ctl, idl);
      set_ins(7'b1100011, 3'b001, 1'b0); en = 1'b1;
      fetch_dec("bne0");
      en = 1'b0;
      tick(); chk("bne0.exec", ctl, cv(1,0,1,1,2'd0,4'h6,0,0,0,0,1,1,0,1));
      tick(); chk("bne0.instret", instret, 9);

      // reset in MEM of lw
      set_ins(7'b0000011, 3'b010, 1'b0); en = 1'b1;
      fetch_dec("lwr");
      tick(); tick();
      chk("lwr.mem", ctl, cv(0,0,0,0,2'd0,4'h0,1,0,0,0,0,0,0,1));
      reset = 1'b1; en = 1'b0;
      tick(); reset = 1'b0;
      chk("lwr.ctl", ctl, idl);
      chk("lwr.instret", instret, 0);
      tick(); chk("lwr.idle", ctl, idl);

      // illegal opcode
      set_ins(7'b1111111, 3'b000, 1'b0); en = 1'b1;
      fetch_dec("ill");
      tick(); chk("ill.trap", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,0,0,0,0,1,0));
      tick(); chk("ill.sticky", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,0,0,0,0,1,0));
      chk("ill.instret", instret, 0);
      reset = 1'b1; en = 1'b0;
      tick(); reset = 1'b0;
      chk("ill.reset", ctl, idl);

      // sra-style R encoding is illegal
      set_ins(7'b0110011, 3'b101, 1'b1); en = 1'b1;
      fetch_dec("sra");
      tick(); chk("sra.trap", ctl, cv(0,0,0,0,2'd0,4'h0,0,0,0,0,0,0,1,0));
      reset = 1'b1; en = 1'b0;
      tick(); reset = 1'b0;
      chk("sra.reset", ctl, idl);

      // back-to-back branches to wrap the 4-bit counter
      set_ins(7'b1100011, 3'b000, 1'b0); zero = 1'b0; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         int n;
         n = 0;
         do begin
            tick();
            n++;
         end while (!retire && n < 12);
         chk("wrap.retire", retire, 1);
         tick();
         chk("wrap.cnt", instret, 32'((i + 1) % 16));
      end
      en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
